// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i core widths, constants and fetch types
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - show-ahead synchronous FIFO with flush and occupancy count
module fetch_buffer import rv32i_pkg::*; #(
   parameter int DEPTH = 3,
   parameter type T = fetch_entry_t,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  T              wdata,
   input  logic          pop,
   output T              rdata,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   T              mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; readers qualify the head with count.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32i fetch stage: PC, credit-limited imem requests, fetch buffer, redirect drop
module fetch_unit import rv32i_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
   parameter int              FB_DEPTH = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [ILEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc
);

   localparam int CW = $clog2(FB_DEPTH + 1);

   logic [XLEN-1:0] pc;
   logic [CW-1:0]   out_cnt;
   logic [CW-1:0]   out_cnt_next;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   fb_count;
   logic            started;
   logic            accept;
   logic            rsp_keep;
   logic            fb_pop;
   logic [XLEN-1:0] tag_pc;
   fetch_entry_t    fb_in;
   fetch_entry_t    fb_head;

   // Credits cover both in-flight requests and buffered entries, so a response always has room.
   assign imem_req_valid = started &&
                           (({1'b0, out_cnt} + {1'b0, fb_count}) < (CW + 1)'(FB_DEPTH));
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;

   assign out_cnt_next = out_cnt + CW'(accept) - CW'(imem_rsp_valid);
   assign rsp_keep     = imem_rsp_valid && (drop_cnt == '0);
   assign fb_pop       = id_valid && id_ready;
   assign fb_in        = '{pc: tag_pc, instr: imem_rsp_data};

   // Tag queue is never flushed: its occupancy is the outstanding-request count,
   // and stale entries still pop as their dropped responses return.
   fetch_buffer #(
      .DEPTH (FB_DEPTH),
      .T     (logic [XLEN-1:0])
   ) u_tag_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (1'b0),
      .push  (accept),
      .wdata (pc),
      .pop   (imem_rsp_valid),
      .rdata (tag_pc),
      .count (out_cnt)
   );

   fetch_buffer #(
      .DEPTH (FB_DEPTH),
      .T     (fetch_entry_t)
   ) u_fetch_buffer (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (rsp_keep),
      .wdata (fb_in),
      .pop   (fb_pop),
      .rdata (fb_head),
      .count (fb_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= word_align(RESET_PC);
         drop_cnt <= '0;
         started  <= 1'b0;
      end else begin
         started <= 1'b1;
         if (redirect_valid) begin
            pc       <= word_align(redirect_pc);
            drop_cnt <= out_cnt_next;
         end else begin
            if (accept) pc <= pc + XLEN'(4);
            if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   assign id_valid = (fb_count != '0);
   assign id_instr = id_valid ? fb_head.instr : NOP_INSTR;
   assign id_pc    = id_valid ? fb_head.pc : '0;

endmodule
